// File: rtl/oka_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oka_pkg
// Description : Shared types and helpers for the overlap-free Karatsuba
//               carry-less multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package oka_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } oka_state_e;

    function automatic int oka_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Source bit in the full operand for bit i of the even (odd=0) or odd (odd=1) half.
    function automatic int oka_split_idx(input int i, input bit odd);
        return 2 * i + (odd ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oka_digit_mac.sv
`default_nettype none
// ============================================================================
// Module      : oka_digit_mac
// Description : Carry-less H x D shift-XOR accumulator, one digit per enable.
// Revision    : 1.0 - initial release
// ============================================================================
module oka_digit_mac
    import oka_pkg::*;
#(
    parameter int H  = 33,
    parameter int D  = 3,
    parameter int K  = 11,
    parameter int AW = H + K * D - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [H-1:0]  i_a,
    input  logic [D-1:0]  i_digit,
    output logic [AW-1:0] o_acc_nxt
);

    localparam int c_PW = H + D - 1;
    // Only partial sums before the final digit are stored; the final sum is
    // consumed straight from o_acc_nxt, so the register can be D bits narrower.
    localparam int c_RW = AW - D;

    logic [c_RW-1:0] r_acc;
    logic [c_PW-1:0] w_prod;

    always_comb begin
        w_prod = '0;
        for (int j = 0; j < D; j++) begin
            if (i_digit[j]) begin
                w_prod = w_prod ^ (c_PW'(i_a) << j);
            end
        end
    end

    assign o_acc_nxt = {r_acc, {D{1'b0}}} ^ AW'(w_prod);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_nxt[c_RW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/oka_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : oka_seq_mult
// Description : Sequential GF(2)[x] multiplier, one-level overlap-free
//               Karatsuba split with three digit-serial half products.
// Revision    : 1.0 - initial release
// ============================================================================
module oka_seq_mult
    import oka_pkg::*;
#(
    parameter int N = 66,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y
);

    localparam int c_H  = N / 2;
    localparam int c_K  = oka_ceil_div(c_H, D);
    localparam int c_KD = c_K * D;
    localparam int c_AW = c_H + c_KD - 1;
    localparam int c_PW = 2 * c_H - 1;
    localparam int c_CW = (c_K > 1) ? $clog2(c_K) : 1;

    oka_state_e       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [c_H-1:0]   r_ae, r_ao, r_am;
    logic [c_KD-1:0]  r_be, r_bo, r_bm;
    logic [2*N-2:0]   r_y;
    logic             r_out_valid;

    logic [c_H-1:0]   w_ae, w_ao, w_be, w_bo;
    logic             w_in_ready, w_accept, w_busy;
    logic [c_AW-1:0]  w_acc1, w_acc2, w_acc3;
    logic [c_PW-1:0]  w_p1, w_p2, w_p3, w_mid;
    logic [2*c_H-1:0] w_p1x, w_p2s;
    logic [2*N-2:0]   w_y;

    for (genvar i = 0; i < c_H; i++) begin : g_split
        assign w_ae[i] = a[oka_split_idx(i, 1'b0)];
        assign w_ao[i] = a[oka_split_idx(i, 1'b1)];
        assign w_be[i] = b[oka_split_idx(i, 1'b0)];
        assign w_bo[i] = b[oka_split_idx(i, 1'b1)];
    end

    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_busy     = (r_state == BUSY);

    oka_digit_mac #(.H(c_H), .D(D), .K(c_K), .AW(c_AW)) u_mac_p1 (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_busy),
        .i_a(r_ae), .i_digit(r_be[c_KD-1 -: D]), .o_acc_nxt(w_acc1)
    );
    oka_digit_mac #(.H(c_H), .D(D), .K(c_K), .AW(c_AW)) u_mac_p2 (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_busy),
        .i_a(r_ao), .i_digit(r_bo[c_KD-1 -: D]), .o_acc_nxt(w_acc2)
    );
    oka_digit_mac #(.H(c_H), .D(D), .K(c_K), .AW(c_AW)) u_mac_p3 (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_busy),
        .i_a(r_am), .i_digit(r_bm[c_KD-1 -: D]), .o_acc_nxt(w_acc3)
    );

    // Recombination uses the accumulators' next values so y can be captured
    // on the same edge that folds in the last digit.
    assign w_p1  = w_acc1[c_PW-1:0];
    assign w_p2  = w_acc2[c_PW-1:0];
    assign w_p3  = w_acc3[c_PW-1:0];
    assign w_mid = w_p1 ^ w_p2 ^ w_p3;
    assign w_p1x = {1'b0, w_p1};
    assign w_p2s = {w_p2, 1'b0};

    for (genvar k = 0; k < 2 * c_H; k++) begin : g_even
        assign w_y[2*k] = w_p1x[k] ^ w_p2s[k];
    end
    for (genvar k = 0; k < 2 * c_H - 1; k++) begin : g_odd
        assign w_y[2*k+1] = w_mid[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_ae        <= '0;
            r_ao        <= '0;
            r_am        <= '0;
            r_be        <= '0;
            r_bo        <= '0;
            r_bm        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= BUSY;
                end
                BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_be  <= r_be << D;
                    r_bo  <= r_bo << D;
                    r_bm  <= r_bm << D;
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_y         <= w_y;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= in_valid ? BUSY : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept) begin
                r_cnt <= c_CW'(c_K - 1);
                r_ae  <= w_ae;
                r_ao  <= w_ao;
                r_am  <= w_ae ^ w_ao;
                r_be  <= c_KD'(w_be);
                r_bo  <= c_KD'(w_bo);
                r_bm  <= c_KD'(w_be ^ w_bo);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_oka_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_oka_seq_mult
// Description : Scoreboard bench for oka_seq_mult at N=66/D=3 and N=10/D=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oka_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv66, ir66, ov66, or66;
    logic [65:0] a66, b66;
    logic [130:0] y66;
    logic        iv10, ir10, ov10, or10;
    logic [9:0]  a10, b10;
    logic [18:0] y10;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [130:0] q66[$];
    logic [18:0]  q10[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oka_seq_mult #(.N(66), .D(3)) u_dut66 (
        .clk(clk), .rst(rst), .in_valid(iv66), .in_ready(ir66), .a(a66), .b(b66),
        .out_valid(ov66), .out_ready(or66), .y(y66)
    );
    oka_seq_mult #(.N(10), .D(2)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10), .a(a10), .b(b10),
        .out_valid(ov10), .out_ready(or10), .y(y10)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [130:0] act, input logic [130:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [130:0] clmul66(input logic [65:0] x, input logic [65:0] z);
        logic [130:0] r = '0;
        for (int i = 0; i < 66; i++) if (z[i]) r = r ^ ({65'b0, x} << i);
        return r;
    endfunction

    function automatic logic [18:0] clmul10(input logic [9:0] x, input logic [9:0] z);
        logic [18:0] r = '0;
        for (int i = 0; i < 10; i++) if (z[i]) r = r ^ ({9'b0, x} << i);
        return r;
    endfunction

    // Monitors: pop on every transfer cycle, flag any output with nothing expected.
    always @(negedge clk) begin
        logic [130:0] e66;
        if (!rst && ov66 === 1'b1 && or66 === 1'b1) begin
            if (q66.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL y66_unexpected: got %h required no output", y66);
            end else begin
                e66 = q66.pop_front();
                chkw("y66", y66, e66);
            end
        end
    end

    always @(negedge clk) begin
        logic [18:0] e10;
        if (!rst && ov10 === 1'b1 && or10 === 1'b1) begin
            if (q10.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL y10_unexpected: got %h required no output", y10);
            end else begin
                e10 = q10.pop_front();
                chkw("y10", 131'(y10), 131'(e10));
            end
        end
    end

    task automatic send66(input logic [65:0] xa, input logic [65:0] xb,
                          input logic [130:0] exp, input bit push, output int e0);
        bit ok = 1'b0;
        if (push) q66.push_back(exp);
        a66 = xa; b66 = xb; iv66 = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ir66 === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send66_timeout: got in_ready=0 required 1");
        end
        @(posedge clk); #1;
        iv66 = 1'b0;
        e0 = cyc;
    endtask

    task automatic send10(input logic [9:0] xa, input logic [9:0] xb,
                          input logic [18:0] exp, output int e0);
        bit ok = 1'b0;
        q10.push_back(exp);
        a10 = xa; b10 = xb; iv10 = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ir10 === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send10_timeout: got in_ready=0 required 1");
        end
        @(posedge clk); #1;
        iv10 = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_ov66(output int t);
        bit ok = 1'b0;
        t = cyc;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ov66 === 1'b1) begin ok = 1'b1; t = cyc; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL wait_ov66_timeout: got out_valid=0 required 1");
        end
    endtask

    task automatic wait_ov10(output int t);
        bit ok = 1'b0;
        t = cyc;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ov10 === 1'b1) begin ok = 1'b1; t = cyc; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL wait_ov10_timeout: got out_valid=0 required 1");
        end
    endtask

    initial begin
        int e0, t1, t2;
        bit seen;
        logic [95:0] ra, rb;
        logic [31:0] sa, sb;

        iv66 = 1'b0; a66 = '0; b66 = '0; or66 = 1'b1;
        iv10 = 1'b0; a10 = '0; b10 = '0; or10 = 1'b1;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready66", ir66, 1'b1);
        chk1("rst_out_valid66", ov66, 1'b0);
        chkw("rst_y66", y66, 131'd0);
        chk1("rst_in_ready10", ir10, 1'b1);
        @(posedge clk); #1;

        // 1*1 and accept-to-valid latency
        send66(66'd1, 66'd1, 131'd1, 1'b1, e0);
        wait_ov66(t1);
        chki("lat66", t1 - e0 + 1, 12);
        @(posedge clk); #1;

        // MSB-only operands, then 3*3 held valid through BUSY and taken from DONE
        send66(66'd1 << 65, 66'd1 << 65, 131'd1 << 130, 1'b1, e0);
        a66 = 66'd3; b66 = 66'd3; iv66 = 1'b1;
        q66.push_back(131'd5);
        wait_ov66(t1);
        chk1("b2b_in_ready", ir66, 1'b1);
        @(posedge clk); #1;
        iv66 = 1'b0;
        wait_ov66(t2);
        chki("b2b_gap", t2 - t1, 12);
        @(posedge clk); #1;

        // Back-pressure in DONE
        or66 = 1'b0;
        send66(66'h5, 66'h3, 131'hF, 1'b1, e0);
        wait_ov66(t1);
        for (int i = 0; i < 5; i++) begin
            chk1("bp_out_valid", ov66, 1'b1);
            chkw("bp_y_stable", y66, 131'hF);
            chk1("bp_in_ready", ir66, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        or66 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("bp_after_xfer_ov", ov66, 1'b0);
        chki("bp_one_xfer", q66.size(), 0);
        @(posedge clk); #1;

        // Directed plus random streamed back-to-back
        send66(66'hFF, 66'h3, 131'h101, 1'b1, e0);
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom()};
            send66(ra[65:0], rb[65:0], clmul66(ra[65:0], rb[65:0]), 1'b1, e0);
        end
        for (int i = 0; i < 200 && q66.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;

        // Reset during busy cycle 4 discards the operation
        send66(66'h7, 66'h7, 131'd0, 1'b0, e0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("abort_out_valid", ov66, 1'b0);
        chk1("abort_in_ready", ir66, 1'b1);
        chkw("abort_y", y66, 131'd0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov66 !== 1'b0) seen = 1'b1;
        end
        chk1("abort_no_stale", seen, 1'b0);
        @(posedge clk); #1;
        send66(66'h3, 66'h1, 131'h3, 1'b1, e0);

        // N=10, D=2: digit size does not divide the half width
        send10(10'h3FF, 10'h3FF, 19'h55555, e0);
        wait_ov10(t1);
        chki("lat10", t1 - e0 + 1, 4);
        @(posedge clk); #1;
        send10(10'h201, 10'h3, 19'h603, e0);
        for (int i = 0; i < 4; i++) begin
            sa = $urandom();
            sb = $urandom();
            send10(sa[9:0], sb[9:0], clmul10(sa[9:0], sb[9:0]), e0);
        end

        for (int i = 0; i < 200 && (q66.size() != 0 || q10.size() != 0); i++) @(negedge clk);
        chki("q66_drained", q66.size(), 0);
        chki("q10_drained", q10.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oka_seq_mult.md
OKA_SEQ_MULT -- requirements
Module: oka_seq_mult

Interface
REQ-001 Parameter N, default 66, meaning operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter D, default 3, meaning digit size in bits processed per busy cycle; SHALL satisfy 1 <= D <= N/2.
REQ-003 Derived constants SHALL be: H = N/2 (half width) and K = ceil(H/D) (busy cycles).
REQ-004 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  N  operand A, GF(2)[x] polynomial, bit i = coefficient of x^i.
- b  in  N  operand B, same encoding as a.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- y  out  2N-1  carry-less product a*b.

Function
REQ-005 The block SHALL compute y = a*b over GF(2), with no carries, using a one-level overlap-free Karatsuba split. Operand halves:
- ae/be = even-indexed bits.
- ao/bo = odd-indexed bits.
- am = ae^ao, bm = be^bo.
REQ-006 Three H-bit products SHALL be formed in parallel:
- P1 = ae*be
- P2 = ao*bo
- P3 = am*bm
REQ-007 Recombination: y[2k] = P1[k] ^ P2[k-1]; y[2k+1] = (P1^P2^P3)[k].
- Out-of-range terms count as 0.
- Recombination is overlap-free: only XOR, no shifting adders.
REQ-008 FSM states SHALL be IDLE, BUSY and DONE.
REQ-009 IDLE -> BUSY when in_valid & in_ready.
- The block registers the six half-operands.
- The digit counter loads K-1.
- The three accumulators clear.
REQ-010 In BUSY, each cycle SHALL process one D-bit digit of be, bo and bm, MSB digit first:
- acc = (acc << D) ^ (half_a * digit).
- The counter decrements.
REQ-011 Half operands of the b side SHALL be zero-extended at the MSB end to K*D bits when D does not divide H.
REQ-012 BUSY -> DONE after the cycle with counter = 0. In that transition y SHALL be registered from recombination, and out_valid SHALL be asserted.
- Latency from the accept edge to the first out_valid cycle = K+1 cycles.
REQ-013 In DONE, out_valid and y SHALL hold stable until out_ready = 1.
REQ-014 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready = 1. It SHALL be 0 otherwise.
REQ-015 DONE with out_ready & in_valid SHALL go directly to BUSY with the new operands (back-to-back, no bubble).
- DONE with out_ready & !in_valid SHALL go to IDLE.
REQ-016 in_valid in BUSY SHALL be ignored, with no operand capture.
REQ-017 out_valid SHALL be 0 in IDLE and BUSY.

Reset
REQ-018 When rst = 1 at a clock edge, the block SHALL set state = IDLE, out_valid = 0, y = 0, counter = 0 and accumulators = 0.
REQ-019 Reset asserted in BUSY or DONE SHALL abort the operation. The pending result SHALL be discarded and never presented.
REQ-020 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-021 A shared package oka_pkg SHALL hold:
- the state enumeration (IDLE/BUSY/DONE);
- a ceil-divide function used for K;
- the even/odd split function.
REQ-022 The block SHALL use one sub-module, oka_digit_mac, a carry-less H-bit x D-bit shift-XOR accumulator with clear and enable.
- It SHALL be instantiated three times (P1, P2, P3).
REQ-023 Recombination SHALL be combinational logic inside oka_seq_mult, feeding the y register.

Verification
REQ-024 N=66, D=3, a=1, b=1, accepted at cycle 0 -> out_valid at cycle 12, y=1.
REQ-025 N=66, D=3, a=2^65, b=2^65 -> y=2^130 (MSB only).
- Then a=3, b=3 back-to-back with out_ready=1 -> second y=5, with no idle cycle between products.
REQ-026 N=10, D=2 (K=3, non-dividing digit), a=0x3FF, b=0x3FF -> y=0x55555 after 4 cycles. Random operands SHALL match a bitwise carry-less reference model.
REQ-027 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> y and out_valid are stable and in_ready=0 throughout.
- Then out_ready=1 -> exactly one transfer.
REQ-028 Reset in BUSY: assert rst at busy cycle 4 for 1 cycle -> next cycle out_valid=0 and in_ready=1, and no stale y is ever presented.
- A fresh a=0x3, b=0x1 then yields y=0x3.
